alu_seq_ctrl: RTL and testbench

- Issue/sequencing controller between the instruction control unit and the shared combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and latches the operands.
- Single-cycle ops (add, sub, logic, shifts, rotates) are dispatched to the external ALU, and its result is captured.
- MUL and DIV are executed iteratively in-block over 32 cycles, producing a 64-bit HI/LO result; results are held until the consumer accepts them.

---
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/alu_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the instruction control unit and the
// ALU issue/sequencing controller.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             out_err;
  logic             out_dz;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_err, out_dz
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_err, out_dz
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Issue/sequencing controller for the shared combinational ALU.
// Single-cycle ops are dispatched to the external ALU. MUL (signed Booth)
// and DIV (unsigned restoring) run iteratively in this block. ITER is
// expected to equal WIDTH.
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             clear,
  alu_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;

  typedef enum logic [2:0] {IDLE, EXEC, MULRUN, DIVRUN, DONE} state_t;
  state_t state, state_nxt;

  logic             accept;
  logic             single_op;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [CW-1:0]    cnt;
  logic             fin;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             err_q, dz_q;
  logic [WIDTH:0]   a_ext, booth_sum, rem_shift, rem_sub;

  assign accept    = bus.in_valid && (state == IDLE);
  assign a_ext     = {a_q[WIDTH-1], a_q};
  assign rem_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, b_q};

  assign bus.out_lo  = lo_q;
  assign bus.out_hi  = hi_q;
  assign bus.out_err = err_q;
  assign bus.out_dz  = dz_q;

  // Classify the incoming opcode as one the external ALU handles in one cycle
  always_comb begin
    single_op = 1'b0;
    case (bus.in_op)
      4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: single_op = 1'b1;
      default: single_op = 1'b0;
    endcase
  end

  // Booth recoding of the current multiplier bit pair into add/sub/hold
  always_comb begin
    booth_sum = p;
    case ({q[0], qm1})
      2'b10:   booth_sum = p - a_ext;
      2'b01:   booth_sum = p + a_ext;
      default: booth_sum = p;
    endcase
  end

  // State register; clear aborts any operation in flight
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (single_op)                state_nxt = EXEC;
          else if (bus.in_op == OP_MUL) state_nxt = MULRUN;
          else if (bus.in_op == OP_DIV) state_nxt = DIVRUN;
          else                          state_nxt = DONE;
        end
      end
      EXEC:    state_nxt = DONE;
      MULRUN:  if (fin) state_nxt = DONE;
      DIVRUN:  if (fin) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Operand latching, ALU dispatch, iterative MUL/DIV and result capture
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      a_q    <= '0;
      b_q    <= '0;
      p      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      fin    <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      err_q  <= 1'b0;
      dz_q   <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            err_q <= 1'b0;
            dz_q  <= 1'b0;
            cnt   <= '0;
            fin   <= 1'b0;
            qm1   <= 1'b0;
            if (single_op) begin
              alu_a  <= bus.in_a;
              alu_b  <= bus.in_b;
              alu_op <= bus.in_op;
            end else if (bus.in_op == OP_MUL) begin
              p <= '0;
              q <= bus.in_b;
            end else if (bus.in_op == OP_DIV) begin
              p <= '0;
              q <= bus.in_a;
            end else begin
              lo_q  <= '0;
              hi_q  <= '0;
              err_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          lo_q   <= alu_result;
          hi_q   <= '0;
          alu_op <= 4'b0000;
        end
        MULRUN: begin
          if (!fin) begin
            p   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q   <= {booth_sum[0], q[WIDTH-1:1]};
            qm1 <= q[0];
            cnt <= cnt + 1'b1;
            fin <= (cnt == LAST);
          end else begin
            hi_q <= p[WIDTH-1:0];
            lo_q <= q;
          end
        end
        DIVRUN: begin
          if (!fin) begin
            if (rem_sub[WIDTH]) begin
              p <= rem_shift;
              q <= {q[WIDTH-2:0], 1'b0};
            end else begin
              p <= rem_sub;
              q <= {q[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            fin <= (cnt == LAST);
          end else begin
            lo_q <= q;
            hi_q <= p[WIDTH-1:0];
            dz_q <= (b_q == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard testbench for alu_seq_ctrl: directed cases plus randomized ops,
// expected results from a plain-arithmetic reference model.
module tb_alu_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    logic        dz;
    int          lat;
  } exp_t;

  logic             clock;
  logic             clear;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             busy;

  alu_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_ctrl #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .busy(busy)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_mode = 0;
  logic prev_valid = 1'b0;
  exp_t expq[$];
  int   accq[$];
  exp_t mon_exp;
  int   mon_acc;

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising-edge counter used for latency measurement
  always @(posedge clock) cyc <= cyc + 1;

  // Hard stop in case something hangs outside a bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int                 sh;
    logic signed [31:0] sa;
    logic [31:0]        r;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      4'h1:    r = a + b;
      4'h2:    r = a - b;
      4'h5:    r = a & b;
      4'h6:    r = a | b;
      4'h7:    r = a >> sh;
      4'h8:    r = sa >>> sh;
      4'h9:    r = a << sh;
      4'hA:    r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      4'hB:    r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // External ALU model driven by the controller's dispatch outputs
  always_comb alu_result = aluRef(alu_op, alu_a, alu_b);

  function automatic exp_t refModel(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    exp_t   e;
    longint sa, sb, prod;
    e.lo = 32'h0; e.hi = 32'h0; e.err = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      4'h0, 4'hC, 4'hD, 4'hE, 4'hF: begin
        e.err = 1'b1;
        e.lat = 0;
      end
      4'h4: begin
        sa = $signed(a);
        sb = $signed(b);
        prod = sa * sb;
        e.lo = prod[31:0];
        e.hi = prod[63:32];
        e.lat = ITER + 1;
      end
      4'h3: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
        e.lat = ITER + 1;
      end
      default: e.lo = aluRef(op, a, b);
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: record accepts, and score each result when out_valid rises
  always @(negedge clock) begin
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accq.push_back(cyc + 1);
    if (bus.out_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (expq.size() == 0 || accq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got out_valid=1, wanted no pending op");
      end else begin
        mon_exp = expq.pop_front();
        mon_acc = accq.pop_front();
        checkOutput("out_lo", bus.out_lo, mon_exp.lo);
        checkOutput("out_hi", bus.out_hi, mon_exp.hi);
        checkOutput("out_err", bus.out_err, mon_exp.err);
        checkOutput("out_dz", bus.out_dz, mon_exp.dz);
        checkOutput("latency", cyc - mon_acc, mon_exp.lat);
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
    if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    stepCycle();
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      stepCycle();
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=%0b, wanted 1", bus.in_ready);
      return;
    end
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    expq.push_back(refModel(op, a, b));
    stepCycle();
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom();
    bus.in_b     = $urandom();
    bus.in_op    = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while ((expq.size() != 0 || bus.in_ready !== 1'b1) && waited < 300) begin
      stepCycle();
      waited++;
    end
    if (expq.size() != 0 || bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got pending=%0d, wanted 0", name, expq.size());
    end
  endtask

  // Directed and randomized stimulus
  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          w;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'h0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clock);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_lo", bus.out_lo, 0);
    checkOutput("rst_out_hi", bus.out_hi, 0);
    checkOutput("rst_flags", {bus.out_err, bus.out_dz}, 0);
    checkOutput("rst_alu", {alu_a, alu_b, alu_op}, 0);
    @(negedge clock);
    clear = 1'b1;

    applyStimulus(4'h4, 32'hFFFF_FFFD, 32'd7);
    @(negedge clock);
    checkOutput("mul_busy", busy, 1);
    checkOutput("mul_in_ready", bus.in_ready, 0);
    drain("mul");

    applyStimulus(4'h3, 32'd100, 32'd7);
    applyStimulus(4'h3, 32'd5, 32'd0);
    drain("div");

    applyStimulus(4'h1, 32'd5, 32'd3);
    @(negedge clock);
    checkOutput("exec_alu_op", alu_op, 4'h1);
    checkOutput("exec_alu_a", alu_a, 32'd5);
    checkOutput("exec_alu_b", alu_b, 32'd3);
    applyStimulus(4'h9, 32'h8000_0001, 32'd1);
    drain("alu");

    applyStimulus(4'hF, $urandom(), $urandom());
    applyStimulus(4'h6, 32'hF0F0_0000, 32'h0000_0F0F);
    @(negedge clock);
    checkOutput("err_cleared", bus.out_err, 0);
    drain("err");

    bus.out_ready = 1'b0;
    applyStimulus(4'h2, 32'd10, 32'd4);
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 10) begin
      stepCycle();
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("bp_out_valid", bus.out_valid, 1);
      checkOutput("bp_in_ready", bus.in_ready, 0);
      checkOutput("bp_out_lo", bus.out_lo, 32'd6);
      checkOutput("bp_out_hi", bus.out_hi, 32'd0);
    end
    stepCycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stepCycle();
    @(negedge clock);
    checkOutput("bp_release_in_ready", bus.in_ready, 1);
    checkOutput("bp_release_out_valid", bus.out_valid, 0);

    applyStimulus(4'h4, $urandom(), $urandom());
    repeat (10) stepCycle();
    @(negedge clock);
    clear = 1'b0;
    #1;
    checkOutput("abort_state", {busy, bus.out_valid, bus.in_ready}, 3'b001);
    checkOutput("abort_lo_hi", {bus.out_lo, bus.out_hi}, 0);
    checkOutput("abort_flags", {bus.out_err, bus.out_dz}, 0);
    checkOutput("abort_alu", {alu_a, alu_b, alu_op}, 0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    expq.delete();
    accq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abort_no_valid", {bus.out_valid, busy}, 0);
    end
    applyStimulus(4'h4, 32'h8000_0000, 32'h8000_0000);
    drain("mul_min");

    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (($urandom_range(0, 2)) == 0) rop = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'h4;
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      applyStimulus(rop, ra, rb);
    end
    rand_mode     = 1'b0;
    bus.out_ready = 1'b1;
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
